gray_counter_param: RTL and testbench

// - Parametrised WIDTH-bit Gray-code counter: up/down, parallel load, wrap or saturate mode, sticky flags.
// - Generalises the fixed 3-bit up-only Gray counter.
// - Used as a generic sequencer/pointer source; the Gray output is safe to pass to other logic (one bit changes per step).

---
 rtl/gray_counter_param_pkg.sv | 27 ++
 rtl/gray_counter_param_if.sv | 26 ++
 rtl/gray_counter_param_gray2bin.sv | 16 +
 rtl/gray_counter_param.sv | 96 +++++++++
 tb/tb_gray_counter_param.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/gray_counter_param_pkg.sv
// Shared Gray/binary conversion helpers and the per-edge operation encoding
// used by the parametrised Gray counter.
package gray_counter_param_pkg;

    localparam int MAX_W = 32;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_CLEAR,
        OP_LOAD,
        OP_UP,
        OP_DOWN
    } cnt_op_e;

    function automatic logic [MAX_W-1:0] bin2gray_f(input logic [MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Zero-extended input, so XOR-ing every right shift gives the prefix XOR from the MSB.
    function automatic logic [MAX_W-1:0] gray2bin_f(input logic [MAX_W-1:0] g);
        logic [MAX_W-1:0] b;
        b = g;
        for (int i = 1; i < MAX_W; i++) b = b ^ (g >> i);
        return b;
    endfunction

endpackage

// File: rtl/gray_counter_param_if.sv
// Control and result bundle of the Gray counter; master drives controls,
// slave (the counter) drives the registered results.
interface gray_counter_param_if #(
    parameter int WIDTH = 3
);
    logic             Clear;
    logic             Load;
    logic [WIDTH-1:0] Load_val;
    logic             En;
    logic             Dir;
    logic [WIDTH-1:0] Output;
    logic [WIDTH-1:0] Bin;
    logic             Overflow;
    logic             Underflow;
    logic             Wrap;

    modport master (
        output Clear, Load, Load_val, En, Dir,
        input  Output, Bin, Overflow, Underflow, Wrap
    );

    modport slave (
        input  Clear, Load, Load_val, En, Dir,
        output Output, Bin, Overflow, Underflow, Wrap
    );
endinterface

// File: rtl/gray_counter_param_gray2bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all
// Gray bits at and above it.
module gray_counter_param_gray2bin #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    assign bin[WIDTH-1] = gray[WIDTH-1];

    for (genvar i = WIDTH - 2; i >= 0; i--) begin : g_pfx
        assign bin[i] = bin[i+1] ^ gray[i];
    end

endmodule

// File: rtl/gray_counter_param.sv
// Parametrised up/down Gray counter with load, clear, wrap/saturate ends and
// sticky over/underflow flags; all outputs come straight from flops.
module gray_counter_param
    import gray_counter_param_pkg::*;
#(
    parameter int               WIDTH     = 3,
    parameter int               SATURATE  = 0,
    parameter logic [WIDTH-1:0] INIT_GRAY = '0
) (
    input  logic                 Clk,
    input  logic                 Reset,
    gray_counter_param_if.slave  bus
);

    localparam logic [WIDTH-1:0] INIT_BIN = WIDTH'(gray2bin_f(MAX_W'(INIT_GRAY)));

    cnt_op_e          op;
    logic [WIDTH-1:0] load_bin;
    logic             at_top, at_zero;

    logic [WIDTH-1:0] b_d, b_q;
    logic [WIDTH-1:0] gray_d, gray_q;
    logic             ovf_d, ovf_q;
    logic             unf_d, unf_q;
    logic             wrap_d, wrap_q;

    gray_counter_param_gray2bin #(.WIDTH(WIDTH)) u_load_g2b (
        .gray (bus.Load_val),
        .bin  (load_bin)
    );

    assign at_top  = &b_q;
    assign at_zero = ~|b_q;

    always_comb begin
        op = OP_HOLD;
        if (bus.Clear)     op = OP_CLEAR;
        else if (bus.Load) op = OP_LOAD;
        else if (bus.En)   op = bus.Dir ? OP_UP : OP_DOWN;
    end

    always_comb begin
        b_d    = b_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        wrap_d = 1'b0;
        case (op)
            OP_CLEAR: begin
                b_d   = INIT_BIN;
                ovf_d = 1'b0;
                unf_d = 1'b0;
            end
            OP_LOAD: b_d = load_bin;
            OP_UP: begin
                // Modular add already wraps all-ones to zero; saturation just holds.
                b_d = (SATURATE != 0 && at_top) ? b_q : b_q + WIDTH'(1);
                if (at_top) begin
                    ovf_d  = 1'b1;
                    wrap_d = 1'b1;
                end
            end
            OP_DOWN: begin
                b_d = (SATURATE != 0 && at_zero) ? b_q : b_q - WIDTH'(1);
                if (at_zero) begin
                    unf_d  = 1'b1;
                    wrap_d = 1'b1;
                end
            end
            default: ;
        endcase
        gray_d = WIDTH'(bin2gray_f(MAX_W'(b_d)));
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            b_q    <= INIT_BIN;
            gray_q <= INIT_GRAY;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            b_q    <= b_d;
            gray_q <= gray_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
            wrap_q <= wrap_d;
        end
    end

    assign bus.Output    = gray_q;
    assign bus.Bin       = b_q;
    assign bus.Overflow  = ovf_q;
    assign bus.Underflow = unf_q;
    assign bus.Wrap      = wrap_q;

endmodule

// File: tb/tb_gray_counter_param.sv
// Scoreboarded bench: directed vectors push expected {gray,bin,ovf,unf,wrap}
// and a monitor compares after each edge; a WIDTH=5 random run checks Gray properties.
module tb_gray_counter_param;

    logic Clk   = 1'b0;
    logic Reset = 1'b0;
    always #5 Clk = ~Clk;

    gray_counter_param_if #(.WIDTH(3)) bus_a ();
    gray_counter_param_if #(.WIDTH(3)) bus_s ();
    gray_counter_param_if #(.WIDTH(5)) bus_r ();

    gray_counter_param #(.WIDTH(3), .SATURATE(0), .INIT_GRAY(3'b000)) u_a (
        .Clk(Clk), .Reset(Reset), .bus(bus_a));
    gray_counter_param #(.WIDTH(3), .SATURATE(1), .INIT_GRAY(3'b011)) u_s (
        .Clk(Clk), .Reset(Reset), .bus(bus_s));
    gray_counter_param #(.WIDTH(5), .SATURATE(0), .INIT_GRAY(5'b00000)) u_r (
        .Clk(Clk), .Reset(Reset), .bus(bus_r));

    typedef struct {
        int         d;
        logic [8:0] ex;
        string      nm;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   rnd_on   = 1'b0;

    wire [8:0] obs_a = {bus_a.Output, bus_a.Bin, bus_a.Overflow, bus_a.Underflow, bus_a.Wrap};
    wire [8:0] obs_s = {bus_s.Output, bus_s.Bin, bus_s.Overflow, bus_s.Underflow, bus_s.Wrap};

    task automatic cmp(input string nm, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%b required=%b", nm, act, exp);
        end
    endtask

    function automatic logic [4:0] g2b5(input logic [4:0] g);
        logic [4:0] b;
        b[4] = g[4];
        for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // Drive one edge's inputs on DUT d (0 = wrap, 1 = saturate); the other one idles.
    task automatic drv(input int d, input logic clr, input logic ld, input logic [2:0] lv,
                       input logic en, input logic dir, input logic [8:0] ex, input string nm);
        exp_t e;
        @(negedge Clk);
        bus_a.Clear = 1'b0; bus_a.Load = 1'b0; bus_a.En = 1'b0;
        bus_s.Clear = 1'b0; bus_s.Load = 1'b0; bus_s.En = 1'b0;
        if (d == 0) begin
            bus_a.Clear = clr; bus_a.Load = ld; bus_a.Load_val = lv; bus_a.En = en; bus_a.Dir = dir;
        end else begin
            bus_s.Clear = clr; bus_s.Load = ld; bus_s.Load_val = lv; bus_s.En = en; bus_s.Dir = dir;
        end
        e.d = d; e.ex = ex; e.nm = nm;
        q.push_back(e);
    endtask

    // Scoreboard monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                cmp(e.nm, (e.d == 0) ? obs_a : obs_s, e.ex);
            end
        end
    end

    // Property monitor for the random run
    initial begin
        logic [4:0] prev;
        bit         have_prev;
        have_prev = 1'b0;
        prev      = '0;
        forever begin
            @(posedge Clk);
            #1;
            if (rnd_on) begin
                if (have_prev)
                    cmp("rnd_hamming_le1", 9'($countones(bus_r.Output ^ prev) <= 1), 9'd1);
                cmp("rnd_bin_vs_gray", 9'(bus_r.Bin), 9'(g2b5(bus_r.Output)));
                prev      = bus_r.Output;
                have_prev = 1'b1;
            end
        end
    end

    logic [8:0] up_tab [8] = '{9'b001_001_000, 9'b011_010_000, 9'b010_011_000, 9'b110_100_000,
                               9'b111_101_000, 9'b101_110_000, 9'b100_111_000, 9'b000_000_101};

    initial begin
        exp_t e;
        bus_a.Clear = 0; bus_a.Load = 0; bus_a.Load_val = '0; bus_a.En = 0; bus_a.Dir = 0;
        bus_s.Clear = 0; bus_s.Load = 0; bus_s.Load_val = '0; bus_s.En = 0; bus_s.Dir = 0;
        bus_r.Clear = 0; bus_r.Load = 0; bus_r.Load_val = '0; bus_r.En = 0; bus_r.Dir = 0;

        @(negedge Clk);
        cmp("reset_a", obs_a, 9'b000_000_000);
        cmp("reset_s", obs_s, 9'b011_010_000);
        Reset = 1'b1;

        // Wrap DUT: full up cycle, wrap into overflow
        for (int i = 0; i < 8; i++) drv(0, 0, 0, 3'b000, 1, 1, up_tab[i], $sformatf("a_up%0d", i));
        drv(0, 0, 0, 3'b000, 1, 1, 9'b001_001_100, "a_up_after_wrap");
        drv(0, 0, 1, 3'b000, 0, 0, 9'b000_000_100, "a_load000");
        drv(0, 0, 0, 3'b000, 1, 0, 9'b100_111_111, "a_down_wrap");
        drv(0, 0, 0, 3'b000, 0, 1, 9'b100_111_110, "a_hold");
        drv(0, 0, 1, 3'b110, 1, 1, 9'b110_100_110, "a_load_beats_en");
        drv(0, 0, 0, 3'b000, 1, 1, 9'b111_101_110, "a_up_after_load");
        drv(0, 0, 0, 3'b000, 1, 0, 9'b110_100_110, "a_down");
        drv(0, 1, 1, 3'b101, 1, 1, 9'b000_000_000, "a_clear_beats_load");

        // Saturating DUT
        drv(1, 0, 1, 3'b100, 0, 0, 9'b100_111_000, "s_load100");
        for (int i = 0; i < 3; i++) drv(1, 0, 0, 3'b000, 1, 1, 9'b100_111_101, $sformatf("s_sat_up%0d", i));
        drv(1, 0, 0, 3'b000, 1, 0, 9'b101_110_100, "s_down");
        drv(1, 1, 0, 3'b000, 1, 0, 9'b011_010_000, "s_clear");
        drv(1, 0, 1, 3'b000, 0, 0, 9'b000_000_000, "s_load000");
        drv(1, 0, 0, 3'b000, 1, 0, 9'b000_000_011, "s_sat_down0");
        drv(1, 0, 0, 3'b000, 1, 0, 9'b000_000_011, "s_sat_down1");
        drv(1, 0, 0, 3'b000, 1, 1, 9'b001_001_010, "s_up");

        // Asynchronous reset in the middle of counting
        drv(0, 0, 0, 3'b000, 1, 1, 9'b001_001_000, "a_pre_rst0");
        drv(0, 0, 0, 3'b000, 1, 1, 9'b011_010_000, "a_pre_rst1");
        @(negedge Clk);
        #2 Reset = 1'b0;
        #1;
        cmp("async_reset_a", obs_a, 9'b000_000_000);
        cmp("async_reset_s", obs_s, 9'b011_010_000);
        @(negedge Clk);
        Reset = 1'b1;
        e.d = 0; e.ex = 9'b001_001_000; e.nm = "a_first_after_rst";
        q.push_back(e);
        drv(0, 0, 0, 3'b000, 1, 1, 9'b011_010_000, "a_second_after_rst");
        drv(0, 0, 0, 3'b000, 0, 0, 9'b011_010_000, "a_idle");

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge Clk);
        #2;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain pending=%0d required=0", q.size());
        end

        // Random up/down run on the 5-bit counter
        @(negedge Clk);
        rnd_on = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            bus_r.En  = 1'($urandom_range(0, 3) != 0);
            bus_r.Dir = 1'($urandom_range(0, 1));
            @(negedge Clk);
        end
        rnd_on = 1'b0;
        @(negedge Clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
